// File: rtl/instr_encoder_loader.sv
// Program loader for the 16-bit core. Accepts instruction fields over a
// valid/ready handshake, range-checks and packs them into decoder format,
// buffers legal words in a small FIFO and streams them to instruction memory
// at sequential addresses.
module instr_encoder_loader #(
  parameter int          DEPTH     = 4,
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [2:0]        in_reg_a,
  input  logic [2:0]        in_reg_b,
  input  logic [8:0]        in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_wrap,
  output logic              done
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [PTR_W:0]    PTR_ONE = (PTR_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_fifo [DEPTH];
  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ADDR_W:0]     r_word_count;
  logic                r_err_illegal;
  logic                r_err_wrap;

  logic [15:0]         w_word;
  logic                w_legal;
  logic                w_empty;
  logic                w_full;
  logic                w_one_left;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_start_run;
  logic                w_active;

  // FIFO occupancy from pointers carrying one extra wrap bit
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_one_left = ((r_wr_ptr - r_rd_ptr) == PTR_ONE);

  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_accept    = in_valid && in_ready;
  assign w_push      = w_accept && w_legal;
  assign w_pop       = mem_we && mem_ready;
  assign w_start_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign in_ready    = (r_state == S_RUN) && !w_full;
  assign mem_we      = w_active && !w_empty;
  assign mem_wdata   = mem_we ? r_fifo[r_rd_ptr[PTR_W-1:0]] : 16'h0000;
  assign mem_addr    = r_mem_addr;
  assign word_count  = r_word_count;
  assign err_illegal = r_err_illegal;
  assign err_wrap    = r_err_wrap;
  assign done        = (r_state == S_DONE);

  // Pack the instruction fields by format class and judge immediate range
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch is inferred.
    w_word  = 16'h0000;
    w_legal = 1'b0;
    case (in_opcode)
      4'b0010, 4'b0100, 4'b0110, 4'b0111: begin
        w_word  = {in_opcode, in_reg_a, in_reg_b, 6'b0};
        w_legal = 1'b1;
      end
      4'b0000, 4'b0001, 4'b0101: begin
        w_word  = {in_opcode, in_reg_a, in_imm[6:0], 2'b0};
        w_legal = (in_imm[8:7] == 2'b00);
      end
      4'b0011, 4'b1000, 4'b1001: begin
        w_word  = {in_opcode, in_reg_a, in_imm[5:0], 3'b0};
        w_legal = ((in_imm[8:5] == 4'h0) || (in_imm[8:5] == 4'hF)) &&
                  (in_imm != 9'h000);
      end
      4'b1010, 4'b1011: begin
        w_word  = {in_opcode, in_reg_a, in_imm};
        w_legal = 1'b1;
      end
      default: begin
        w_word  = 16'h0000;
        w_legal = 1'b0;
      end
    endcase
  end

  // Session sequencing; DRAIN ends as soon as the last buffered word leaves
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty || (w_pop && w_one_left)) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FIFO pointers: advance on push/pop, cleared when a session starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_start_run) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers define validity and mem_wdata is gated while empty.
    if (w_push) r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_word;
  end

  // Write address, word counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr    <= BASE;
      r_word_count  <= '0;
      r_err_illegal <= 1'b0;
      r_err_wrap    <= 1'b0;
    end else if (w_start_run) begin
      r_mem_addr    <= BASE;
      r_word_count  <= '0;
      r_err_illegal <= 1'b0;
      r_err_wrap    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_mem_addr   <= r_mem_addr + 1'b1;
        r_word_count <= r_word_count + 1'b1;
        if (r_mem_addr == '1) r_err_wrap <= 1'b1;
      end
      if (w_accept && !w_legal) r_err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (DEPTH=4, ADDR_W=2 so that
// address wrap is reachable). Table-driven sessions plus hand sequences for
// back-pressure and mid-session reset; writes are checked by a scoreboard.
module tb_instr_encoder_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              mem_ready = 1'b0;
  logic [3:0]        in_opcode = '0;
  logic [2:0]        in_reg_a = '0;
  logic [2:0]        in_reg_b = '0;
  logic [8:0]        in_imm = '0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              err_illegal;
  logic              err_wrap;
  logic              done;

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_reg_a(in_reg_a), .in_reg_b(in_reg_b),
    .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count),
    .err_illegal(err_illegal), .err_wrap(err_wrap), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [8:0]  imm;
    logic        last;
    logic        legal;
    logic [15:0] word;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q [$];
  int          n_starts = 0;
  bit          rand_ready = 1'b0;
  bit          forced_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // I-mem side acceptance: random in table runs, forced in hand sequences
  always @(posedge clk) begin
    #1;
    mem_ready = rand_ready ? 1'($urandom_range(0, 1)) : forced_ready;
  end

  // Scoreboard: every accepted write must match the next expected word/address
  int                seen_starts = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic              exp_wrap = 1'b0;
  logic [15:0]       exp_word;
  always @(negedge clk) begin
    if (seen_starts != n_starts) begin
      seen_starts = n_starts;
      exp_addr    = '0;
      exp_wrap    = 1'b0;
    end
    if (rst_n && mem_we && mem_ready) begin
      check("write_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_word = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(exp_addr));
        check("wr_data", 32'(mem_wdata), 32'(exp_word));
        check("wr_wrap_flag", 32'(err_wrap), 32'(exp_wrap));
        if (exp_addr == '1) exp_wrap = 1'b1;
        exp_addr = exp_addr + 1'b1;
      end
    end
  end

  task automatic start_pulse();
    @(posedge clk);
    #1;
    start = 1'b1;
    n_starts++;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                      input logic [8:0] imm, input logic last);
    int k;
    in_opcode = op;
    in_reg_a  = a;
    in_reg_b  = b;
    in_imm    = imm;
    in_last   = last;
    in_valid  = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input int n, input logic ill, input logic wrap);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done", 32'(done), 1);
    check("word_count", 32'(word_count), 32'(n));
    check("err_illegal", 32'(err_illegal), 32'(ill));
    check("err_wrap", 32'(err_wrap), 32'(wrap));
    check("queue_drained", 32'(exp_q.size()), 0);
    check("mem_we_after_done", 32'(mem_we), 0);
    check("in_ready_after_done", 32'(in_ready), 0);
  endtask

  initial begin
    vec_t tbl [18];
    int   legal_n;
    bit   any_ill;
    bit   in_session;

    // session 1: single ADD
    tbl[0]  = '{4'b0100, 3'd3, 3'd5, 9'h000, 1'b1, 1'b1, 16'h4740};
    // session 2: only illegal words
    tbl[1]  = '{4'b0011, 3'd0, 3'd0, 9'h000, 1'b0, 1'b0, 16'h0000};
    tbl[2]  = '{4'b0101, 3'd0, 3'd0, 9'h0C8, 1'b1, 1'b0, 16'h0000};
    // session 3: branch/I6/I7 boundaries
    tbl[3]  = '{4'b1010, 3'd1, 3'd0, 9'h1FC, 1'b0, 1'b1, 16'hA3FC};
    tbl[4]  = '{4'b1000, 3'd0, 3'd0, 9'h1FF, 1'b0, 1'b1, 16'h81F8};
    tbl[5]  = '{4'b0000, 3'd2, 3'd0, 9'h07F, 1'b0, 1'b1, 16'h05FC};
    tbl[6]  = '{4'b0001, 3'd7, 3'd0, 9'h080, 1'b0, 1'b0, 16'h0000};
    tbl[7]  = '{4'b1001, 3'd5, 3'd0, 9'h01F, 1'b0, 1'b1, 16'h9AF8};
    tbl[8]  = '{4'b1001, 3'd5, 3'd0, 9'h020, 1'b0, 1'b0, 16'h0000};
    tbl[9]  = '{4'b0011, 3'd4, 3'd0, 9'h1E0, 1'b1, 1'b1, 16'h3900};
    // session 4: R-type, B zero, I7 zero, illegal opcodes, negative I7
    tbl[10] = '{4'b1100, 3'd1, 3'd1, 9'h001, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{4'b0111, 3'd6, 3'd2, 9'h1FF, 1'b0, 1'b1, 16'h7C80};
    tbl[12] = '{4'b1011, 3'd0, 3'd0, 9'h000, 1'b0, 1'b1, 16'hB000};
    tbl[13] = '{4'b0110, 3'd1, 3'd1, 9'h000, 1'b0, 1'b1, 16'h6240};
    tbl[14] = '{4'b0010, 3'd0, 3'd7, 9'h000, 1'b0, 1'b1, 16'h21C0};
    tbl[15] = '{4'b0001, 3'd3, 3'd0, 9'h000, 1'b0, 1'b1, 16'h1600};
    tbl[16] = '{4'b0101, 3'd3, 3'd0, 9'h1FF, 1'b0, 1'b0, 16'h0000};
    tbl[17] = '{4'b1111, 3'd2, 3'd2, 9'h010, 1'b1, 1'b0, 16'h0000};

    // reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_errors", 32'({err_illegal, err_wrap}), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 0);

    // table-driven sessions with random I-mem back-pressure
    rand_ready = 1'b1;
    in_session = 1'b0;
    legal_n    = 0;
    any_ill    = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (!in_session) begin
        start_pulse();
        in_session = 1'b1;
        legal_n    = 0;
        any_ill    = 1'b0;
      end
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].last);
      if (tbl[i].legal) begin
        exp_q.push_back(tbl[i].word);
        legal_n++;
      end else begin
        any_ill = 1'b1;
      end
      if (tbl[i].last) begin
        wait_done(legal_n, any_ill, logic'(legal_n >= 4));
        in_session = 1'b0;
      end
    end

    // back-pressure: FIFO fills with mem_ready=0, output held, then drains with wrap
    rand_ready   = 1'b0;
    forced_ready = 1'b0;
    repeat (2) @(posedge clk);
    start_pulse();
    send(4'b0100, 3'd3, 3'd5, 9'h000, 1'b0); exp_q.push_back(16'h4740);
    send(4'b1010, 3'd1, 3'd0, 9'h1FC, 1'b0); exp_q.push_back(16'hA3FC);
    send(4'b1000, 3'd0, 3'd0, 9'h1FF, 1'b0); exp_q.push_back(16'h81F8);
    send(4'b1001, 3'd5, 3'd0, 9'h01F, 1'b0); exp_q.push_back(16'h9AF8);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 0);
    check("hold_we", 32'(mem_we), 1);
    check("hold_addr", 32'(mem_addr), 0);
    check("hold_data", 32'(mem_wdata), 32'h4740);
    repeat (2) @(negedge clk);
    check("hold_we_2", 32'(mem_we), 1);
    check("hold_data_2", 32'(mem_wdata), 32'h4740);
    forced_ready = 1'b1;
    send(4'b0010, 3'd0, 3'd7, 9'h000, 1'b1); exp_q.push_back(16'h21C0);
    wait_done(5, 1'b0, 1'b1);

    // reset with two buffered words discards them
    forced_ready = 1'b0;
    repeat (2) @(posedge clk);
    start_pulse();
    send(4'b0110, 3'd1, 3'd1, 9'h000, 1'b0);
    send(4'b1011, 3'd0, 3'd0, 9'h000, 1'b0);
    @(negedge clk);
    check("pre_rst_we", 32'(mem_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(mem_we), 0);
    check("mid_rst_addr", 32'(mem_addr), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_wdata", 32'(mem_wdata), 0);
    exp_q.delete();
    forced_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 0);
    check("post_rst_we", 32'(mem_we), 0);
    check("post_rst_done", 32'(done), 0);
    check("post_rst_count", 32'(word_count), 0);
    start_pulse();
    send(4'b0100, 3'd3, 3'd5, 9'h000, 1'b1); exp_q.push_back(16'h4740);
    wait_done(1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
